// File: rtl/mmc1_pkg.sv
// Shared MMC1 definitions for the CPU write port and the downstream bank-register block.
package mmc1_pkg;

  localparam int MMC1_REG_W = 5;
  localparam int CNT_W      = 3;

  localparam logic [1:0] SEL_CTRL = 2'd0;
  localparam logic [1:0] SEL_CHR0 = 2'd1;
  localparam logic [1:0] SEL_CHR1 = 2'd2;
  localparam logic [1:0] SEL_PRG  = 2'd3;

  localparam logic [MMC1_REG_W-1:0] CTRL_RESET_MASK = 5'b01100;

  // Serial count value at which the incoming bit completes a register value.
  localparam logic [CNT_W-1:0] LAST_CNT = 3'd4;

  // One sampled CPU bus state (everything except M2).
  typedef struct packed {
    logic nromsel;
    logic rnw;
    logic a14;
    logic a13;
    logic d7;
    logic d0;
  } bus_t;

  // Bus state that can never qualify as a write; used as the capture idle value.
  localparam bus_t BUS_IDLE = '{nromsel: 1'b1, rnw: 1'b1, default: 1'b0};

  // New bits enter at the top so the first write lands in bit 0 after five shifts.
  function automatic logic [MMC1_REG_W-1:0] shift_in(
    input logic [MMC1_REG_W-1:0] sr,
    input logic                  d
  );
    return {d, sr[MMC1_REG_W-1:1]};
  endfunction

endpackage

// File: rtl/mmc1_cpu_write_port_if.sv
// CPU bus inputs and register-write outputs of the MMC1 CPU write port.
interface mmc1_cpu_write_port_if;
  import mmc1_pkg::*;

  logic                  M2;
  logic                  nROMSEL;
  logic                  CPU_RnW;
  logic                  CPU_A14;
  logic                  CPU_A13;
  logic                  CPU_D7;
  logic                  CPU_D0;

  logic                  REG_WE;
  logic [1:0]            REG_SEL;
  logic [MMC1_REG_W-1:0] REG_DATA;
  logic                  CTRL_RESET;
  logic [CNT_W-1:0]      SHIFT_CNT;

  modport master (
    output M2, nROMSEL, CPU_RnW, CPU_A14, CPU_A13, CPU_D7, CPU_D0,
    input  REG_WE, REG_SEL, REG_DATA, CTRL_RESET, SHIFT_CNT
  );

  modport slave (
    input  M2, nROMSEL, CPU_RnW, CPU_A14, CPU_A13, CPU_D7, CPU_D0,
    output REG_WE, REG_SEL, REG_DATA, CTRL_RESET, SHIFT_CNT
  );

endinterface

// File: rtl/mmc1_bus_sync.sv
// Synchronizes the asynchronous CPU bus and flags M2 falling edges that follow
// a long-enough high phase, so downstream logic is purely synchronous.
module mmc1_bus_sync
  import mmc1_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_HIGH    = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic i_m2,
  input  bus_t i_bus,
  output logic o_m2,
  output bus_t o_bus,
  output logic o_cycle_end
);

  localparam int SW = $bits(bus_t) + 1;
  localparam int HW = (MIN_HIGH < 1) ? 1 : $clog2(MIN_HIGH + 1);
  localparam logic [HW-1:0] HRUN_MAX = HW'(MIN_HIGH);

  logic [SYNC_STAGES-1:0][SW-1:0] r_sync;
  logic [HW-1:0]                  r_hrun;
  logic                           r_m2_d;
  logic                           w_m2;
  bus_t                           w_bus;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= {i_m2, i_bus};
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
    end
  end

  assign {w_m2, w_bus} = r_sync[SYNC_STAGES-1];

  // Run length only needs to reach MIN_HIGH, so it saturates there.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_hrun <= '0;
      r_m2_d <= 1'b0;
    end else begin
      r_m2_d <= w_m2;
      if (!w_m2)                r_hrun <= '0;
      else if (r_hrun != HRUN_MAX) r_hrun <= r_hrun + 1'b1;
    end
  end

  // r_hrun still holds the finished high-run length in the cycle the fall is seen.
  assign o_cycle_end = r_m2_d & ~w_m2 & (r_hrun >= HRUN_MAX);
  assign o_m2        = w_m2;
  assign o_bus       = w_bus;

endmodule

// File: rtl/mmc1_cpu_write_port.sv
// MMC1 CPU write front end: serial 5-write load, D7 reset and RMW write filter,
// producing one-cycle register-write and control-reset strobes.
module mmc1_cpu_write_port
  import mmc1_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_HIGH    = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  mmc1_cpu_write_port_if.slave  bus
);

  logic                  w_m2_s;
  bus_t                  w_bus_raw;
  bus_t                  w_bus_s;
  logic                  w_cycle_end;

  bus_t                  r_cap;
  logic [MMC1_REG_W-1:0] r_shift;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_prev_write;
  logic                  r_reg_we;
  logic                  r_ctrl_reset;
  logic [1:0]            r_reg_sel;
  logic [MMC1_REG_W-1:0] r_reg_data;

  logic [MMC1_REG_W-1:0] w_shift_nx;
  logic [CNT_W-1:0]      w_cnt_nx;
  logic                  w_prev_nx;
  logic                  w_we_nx;
  logic                  w_cr_nx;
  logic [1:0]            w_sel_nx;
  logic [MMC1_REG_W-1:0] w_data_nx;
  logic                  w_is_write;
  logic                  w_accept;
  logic [MMC1_REG_W-1:0] w_shifted;

  assign w_bus_raw = '{nromsel: bus.nROMSEL, rnw: bus.CPU_RnW, a14: bus.CPU_A14,
                       a13: bus.CPU_A13, d7: bus.CPU_D7, d0: bus.CPU_D0};

  mmc1_bus_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .MIN_HIGH    (MIN_HIGH)
  ) u_sync (
    .CLK         (CLK),
    .RST         (RST),
    .i_m2        (bus.M2),
    .i_bus       (w_bus_raw),
    .o_m2        (w_m2_s),
    .o_bus       (w_bus_s),
    .o_cycle_end (w_cycle_end)
  );

  // Keep the latest high-phase sample; it is what the cycle end acts on.
  always_ff @(posedge CLK) begin
    if (RST)         r_cap <= BUS_IDLE;
    else if (w_m2_s) r_cap <= w_bus_s;
  end

  assign w_is_write = ~r_cap.nromsel & ~r_cap.rnw;
  assign w_accept   = w_cycle_end & w_is_write & ~r_prev_write;
  assign w_shifted  = shift_in(r_shift, r_cap.d0);

  always_comb begin
    w_shift_nx = r_shift;
    w_cnt_nx   = r_cnt;
    w_prev_nx  = r_prev_write;
    w_we_nx    = 1'b0;
    w_cr_nx    = 1'b0;
    w_sel_nx   = r_reg_sel;
    w_data_nx  = r_reg_data;
    if (w_cycle_end) w_prev_nx = w_is_write;
    if (w_accept) begin
      if (r_cap.d7) begin
        w_shift_nx = '0;
        w_cnt_nx   = '0;
        w_cr_nx    = 1'b1;
      end else if (r_cnt == LAST_CNT) begin
        w_data_nx  = w_shifted;
        w_sel_nx   = {r_cap.a14, r_cap.a13};
        w_we_nx    = 1'b1;
        w_shift_nx = '0;
        w_cnt_nx   = '0;
      end else begin
        w_shift_nx = w_shifted;
        w_cnt_nx   = r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_shift      <= '0;
      r_cnt        <= '0;
      r_prev_write <= 1'b0;
      r_reg_we     <= 1'b0;
      r_ctrl_reset <= 1'b0;
      r_reg_sel    <= '0;
      r_reg_data   <= '0;
    end else begin
      r_shift      <= w_shift_nx;
      r_cnt        <= w_cnt_nx;
      r_prev_write <= w_prev_nx;
      r_reg_we     <= w_we_nx;
      r_ctrl_reset <= w_cr_nx;
      r_reg_sel    <= w_sel_nx;
      r_reg_data   <= w_data_nx;
    end
  end

  assign bus.REG_WE     = r_reg_we;
  assign bus.CTRL_RESET = r_ctrl_reset;
  assign bus.REG_SEL    = r_reg_sel;
  assign bus.REG_DATA   = r_reg_data;
  assign bus.SHIFT_CNT  = r_cnt;

endmodule

// File: tb/tb_mmc1_cpu_write_port.sv
// Directed bench for mmc1_cpu_write_port: table of bus cycles plus reset and glitch sequences.
module tb_mmc1_cpu_write_port;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  mmc1_cpu_write_port_if bif();

  mmc1_cpu_write_port #(.SYNC_STAGES(2), .MIN_HIGH(2)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bif)
  );

  typedef struct {
    logic       rnw;
    logic       nrom;
    logic [1:0] sel;
    logic       d7;
    logic       d0;
    int         cnt;
    int         we;
    int         cr;
    int         esel;
    int         edata;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int failures = 0;
  int we_cnt = 0, cr_cnt = 0, both_hi = 0, we_long = 0;
  logic we_d = 1'b0;

  always @(negedge CLK) begin
    if (bif.REG_WE) we_cnt++;
    if (bif.CTRL_RESET) cr_cnt++;
    if (bif.REG_WE && bif.CTRL_RESET) both_hi++;
    if (bif.REG_WE && we_d) we_long++;
    we_d = bif.REG_WE;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rnw, input logic nrom, input logic [1:0] sel,
                              input logic d7, input logic d0, input int cnt, input int we,
                              input int cr, input int esel, input int edata);
    vec_t v;
    v.rnw = rnw; v.nrom = nrom; v.sel = sel; v.d7 = d7; v.d0 = d0;
    v.cnt = cnt; v.we = we; v.cr = cr; v.esel = esel; v.edata = edata;
    return v;
  endfunction

  // One M2 cycle; lat = negedges after the M2 fall until a strobe is seen (-1 = none).
  task automatic cycle(input logic rnw, input logic nrom, input logic [1:0] sel,
                       input logic d7, input logic d0, input int hi, output int lat);
    @(negedge CLK);
    bif.M2 = 1'b0; bif.CPU_RnW = rnw; bif.nROMSEL = nrom;
    bif.CPU_A14 = sel[1]; bif.CPU_A13 = sel[0]; bif.CPU_D7 = d7; bif.CPU_D0 = d0;
    repeat (2) @(negedge CLK);
    bif.M2 = 1'b1;
    repeat (hi) @(negedge CLK);
    bif.M2 = 1'b0;
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge CLK);
      if (lat < 0 && (bif.REG_WE || bif.CTRL_RESET)) lat = k;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_we"}, int'(bif.REG_WE), 0);
    chk({tag, "_cr"}, int'(bif.CTRL_RESET), 0);
    chk({tag, "_sel"}, int'(bif.REG_SEL), 0);
    chk({tag, "_data"}, int'(bif.REG_DATA), 0);
    chk({tag, "_cnt"}, int'(bif.SHIFT_CNT), 0);
  endtask

  initial begin
    int lat, we0, cr0;
    bif.M2 = 0; bif.nROMSEL = 1; bif.CPU_RnW = 1; bif.CPU_A14 = 0; bif.CPU_A13 = 0;
    bif.CPU_D7 = 0; bif.CPU_D0 = 0;

    // {rnw, nrom, sel, d7, d0, cnt, we, cr, held sel, held data}
    // $E000, D0 = 1,0,1,1,0 separated by reads -> 5'b01101
    tbl.push_back(mk(0,0,3,0,1, 1,0,0, 0,0));
    tbl.push_back(mk(1,0,3,0,0, 1,0,0, 0,0));
    tbl.push_back(mk(0,0,3,0,0, 2,0,0, 0,0));
    tbl.push_back(mk(1,0,3,0,0, 2,0,0, 0,0));
    tbl.push_back(mk(0,0,3,0,1, 3,0,0, 0,0));
    tbl.push_back(mk(1,0,3,0,0, 3,0,0, 0,0));
    tbl.push_back(mk(0,0,3,0,1, 4,0,0, 0,0));
    tbl.push_back(mk(1,0,3,0,0, 4,0,0, 0,0));
    tbl.push_back(mk(0,0,3,0,0, 0,1,0, 3,5'h0D));
    // Three writes to $8000 then D7 reset
    tbl.push_back(mk(1,0,0,0,0, 0,0,0, 3,5'h0D));
    tbl.push_back(mk(0,0,0,0,1, 1,0,0, 3,5'h0D));
    tbl.push_back(mk(1,0,0,0,0, 1,0,0, 3,5'h0D));
    tbl.push_back(mk(0,0,0,0,1, 2,0,0, 3,5'h0D));
    tbl.push_back(mk(1,0,0,0,0, 2,0,0, 3,5'h0D));
    tbl.push_back(mk(0,0,0,0,1, 3,0,0, 3,5'h0D));
    tbl.push_back(mk(1,0,0,0,0, 3,0,0, 3,5'h0D));
    tbl.push_back(mk(0,0,0,1,0, 0,0,1, 3,5'h0D));
    // Five writes D0=1 to $A000 -> 5'h1F, sel 1
    for (int i = 1; i <= 5; i++) begin
      tbl.push_back(mk(1,0,1,0,0, i-1,0,0, 3,5'h0D));
      if (i < 5) tbl.push_back(mk(0,0,1,0,1, i,0,0, 3,5'h0D));
      else       tbl.push_back(mk(0,0,1,0,1, 0,1,0, 1,5'h1F));
    end
    // RMW pair, then $6000 write between writes 2 and 3 -> 5'b01011 to $C000
    tbl.push_back(mk(1,0,0,0,0, 0,0,0, 1,5'h1F));
    tbl.push_back(mk(0,0,0,0,1, 1,0,0, 1,5'h1F));
    tbl.push_back(mk(0,0,0,0,0, 1,0,0, 1,5'h1F));
    tbl.push_back(mk(1,0,0,0,0, 1,0,0, 1,5'h1F));
    tbl.push_back(mk(0,0,0,0,1, 2,0,0, 1,5'h1F));
    tbl.push_back(mk(0,1,0,0,1, 2,0,0, 1,5'h1F));
    tbl.push_back(mk(0,0,0,0,0, 3,0,0, 1,5'h1F));
    tbl.push_back(mk(1,0,0,0,0, 3,0,0, 1,5'h1F));
    tbl.push_back(mk(0,0,0,0,1, 4,0,0, 1,5'h1F));
    tbl.push_back(mk(1,0,0,0,0, 4,0,0, 1,5'h1F));
    tbl.push_back(mk(0,0,2,0,0, 0,1,0, 2,5'h0B));

    repeat (4) @(negedge CLK);
    chk_zero("reset");
    RST = 1'b0;

    foreach (tbl[i]) begin
      we0 = we_cnt; cr0 = cr_cnt;
      cycle(tbl[i].rnw, tbl[i].nrom, tbl[i].sel, tbl[i].d7, tbl[i].d0, 4, lat);
      chk($sformatf("v%0d_cnt", i), int'(bif.SHIFT_CNT), tbl[i].cnt);
      chk($sformatf("v%0d_we", i), we_cnt - we0, tbl[i].we);
      chk($sformatf("v%0d_cr", i), cr_cnt - cr0, tbl[i].cr);
      chk($sformatf("v%0d_sel", i), int'(bif.REG_SEL), tbl[i].esel);
      chk($sformatf("v%0d_data", i), int'(bif.REG_DATA), tbl[i].edata);
      if (tbl[i].we + tbl[i].cr > 0) chk($sformatf("v%0d_lat", i), lat, 3);
    end

    // Reset after three writes discards the partial value
    cycle(1,0,1,0,0,4,lat);
    cycle(0,0,1,0,1,4,lat);
    cycle(1,0,1,0,0,4,lat);
    cycle(0,0,1,0,1,4,lat);
    cycle(1,0,1,0,0,4,lat);
    cycle(0,0,1,0,1,4,lat);
    chk("pre_rst_cnt", int'(bif.SHIFT_CNT), 3);
    @(negedge CLK); RST = 1'b1;
    repeat (2) @(negedge CLK);
    chk_zero("midrst");
    RST = 1'b0;
    we0 = we_cnt;
    cycle(0,0,1,0,0,4,lat);
    chk("post_rst_first_cnt", int'(bif.SHIFT_CNT), 1);
    cycle(1,0,1,0,0,4,lat); cycle(0,0,1,0,1,4,lat);
    cycle(1,0,1,0,0,4,lat); cycle(0,0,1,0,0,4,lat);
    cycle(1,0,1,0,0,4,lat); cycle(0,0,1,0,0,4,lat);
    cycle(1,0,1,0,0,4,lat); cycle(0,0,1,0,1,4,lat);
    chk("post_rst_we", we_cnt - we0, 1);
    chk("post_rst_data", int'(bif.REG_DATA), 5'h12);
    chk("post_rst_sel", int'(bif.REG_SEL), 1);

    // One-CLK M2 glitch on a write-like bus: no count, no strobe, no filter state
    cycle(1,0,3,0,0,4,lat);
    we0 = we_cnt; cr0 = cr_cnt;
    cycle(0,0,3,0,1,1,lat);
    chk("glitch_cnt", int'(bif.SHIFT_CNT), 0);
    chk("glitch_strobes", (we_cnt - we0) + (cr_cnt - cr0), 0);
    chk("glitch_lat", lat, -1);
    cycle(0,0,3,0,1,4,lat);
    chk("after_glitch_cnt", int'(bif.SHIFT_CNT), 1);

    chk("we_cr_overlap", both_hi, 0);
    chk("we_width", we_long, 0);
    chk("total_we", we_cnt, 4);
    chk("total_cr", cr_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
